tiny16_ctrl: RTL and testbench



---
 rtl/tiny16_pkg.sv | 43 ++++
 rtl/tiny16_ctrl_if.sv | 46 ++++
 rtl/tiny16_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tiny16_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny16_pkg.sv
// tiny16_pkg: shared definitions for the tiny16 sequencer.
//   - Opcode constants (instruction bits [15:12]).
//   - Sequencer state encodings.
//   - Bit positions of the instruction-register fields.
//   - is_defined_op(): true for opcodes the sequencer implements.
package tiny16_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_WB = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Instruction layout: [15:12] op, [11:8] dst, [7:4] src, [3:0] fn
    localparam int IR_OP_MSB  = 15;
    localparam int IR_OP_LSB  = 12;
    localparam int IR_DST_MSB = 11;
    localparam int IR_DST_LSB = 8;
    localparam int IR_SRC_MSB = 7;
    localparam int IR_SRC_LSB = 4;
    localparam int IR_FN_MSB  = 3;
    localparam int IR_FN_LSB  = 0;

    function automatic logic is_defined_op(input logic [3:0] op);
        logic ok;
        case (op)
            OP_NOP, OP_ALU, OP_LD, OP_ST, OP_LDI, OP_JMP, OP_HLT: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tiny16_ctrl_if.sv
// tiny16_ctrl_if: memory, register-file and ALU port bundle of the tiny16 core.
//   master: the sequencer (drives strobes, addresses, selects, operands).
//   slave : the memory / register file / ALU side (returns read data,
//           register values and the ALU result).
interface tiny16_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    // memory read port
    logic              mem_out_en;
    logic [ADDR_W-1:0] mem_out_addr;
    logic [DATA_W-1:0] mem_out_data;
    // memory write port
    logic              mem_in_en;
    logic [ADDR_W-1:0] mem_in_addr;
    logic [DATA_W-1:0] mem_in_data;
    // register file
    logic [3:0]        rf_src_sel;
    logic [3:0]        rf_dst_sel;
    logic              rf_out_en;
    logic [DATA_W-1:0] rf_src;
    logic [DATA_W-1:0] rf_dst;
    logic              rf_in_en;
    logic [DATA_W-1:0] rf_in;
    // ALU
    logic [3:0]        alu_opcode;
    logic              alu_ar_flag;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [DATA_W-1:0] alu_dst;

    modport master (
        output mem_out_en, mem_out_addr, mem_in_en, mem_in_addr, mem_in_data,
        output rf_src_sel, rf_dst_sel, rf_out_en, rf_in_en, rf_in,
        output alu_opcode, alu_ar_flag, alu_src1, alu_src2,
        input  mem_out_data, rf_src, rf_dst, alu_dst
    );

    modport slave (
        input  mem_out_en, mem_out_addr, mem_in_en, mem_in_addr, mem_in_data,
        input  rf_src_sel, rf_dst_sel, rf_out_en, rf_in_en, rf_in,
        input  alu_opcode, alu_ar_flag, alu_src1, alu_src2,
        output mem_out_data, rf_src, rf_dst, alu_dst
    );

endinterface

// File: rtl/tiny16_ctrl.sv
// tiny16_ctrl: fetch/decode/execute sequencer of the tiny16 core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tiny16_ctrl_if.master (memory read/write, register file, ALU)
//   halted   : high while in HALT
//   illegal  : one-cycle pulse when an undefined opcode executes
// pc, ir and state are registered; all bus outputs are decoded
// combinationally from state and ir, and forced to zero while rst is high.
module tiny16_ctrl
    import tiny16_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    tiny16_ctrl_if.master bus,
    output logic          halted,
    output logic          illegal
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc_s;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [3:0]        op_s, dst_s, src_s, fn_s;

    logic              mem_out_en_s, mem_in_en_s, rf_out_en_s, rf_in_en_s;
    logic              halted_s, illegal_s;
    logic [ADDR_W-1:0] mem_out_addr_s, mem_in_addr_s;
    logic [DATA_W-1:0] mem_in_data_s, rf_in_s, alu_src1_s, alu_src2_s;
    logic [3:0]        rf_src_sel_s, rf_dst_sel_s, alu_opcode_s;

    assign op_s     = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign dst_s    = ir_q[IR_DST_MSB:IR_DST_LSB];
    assign src_s    = ir_q[IR_SRC_MSB:IR_SRC_LSB];
    assign fn_s     = ir_q[IR_FN_MSB:IR_FN_LSB];
    // natural ADDR_W-bit overflow gives the wrap to 0
    assign pc_inc_s = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next-state, pc/ir update and output decode
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        mem_out_en_s   = 1'b0;
        mem_out_addr_s = {ADDR_W{1'b0}};
        mem_in_en_s    = 1'b0;
        mem_in_addr_s  = {ADDR_W{1'b0}};
        mem_in_data_s  = {DATA_W{1'b0}};
        rf_src_sel_s   = 4'h0;
        rf_dst_sel_s   = 4'h0;
        rf_out_en_s    = 1'b0;
        rf_in_en_s     = 1'b0;
        rf_in_s        = {DATA_W{1'b0}};
        alu_opcode_s   = 4'h0;
        alu_src1_s     = {DATA_W{1'b0}};
        alu_src2_s     = {DATA_W{1'b0}};
        halted_s       = 1'b0;
        illegal_s      = 1'b0;
        if (rst) begin
            // outputs stay at zero; the registers reload in always_ff
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_out_en_s   = 1'b1;
                    mem_out_addr_s = pc_q;
                    state_d        = S_DECODE;
                end
                S_DECODE: begin
                    ir_d    = bus.mem_out_data;
                    pc_d    = pc_inc_s;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    rf_src_sel_s = src_s;
                    rf_dst_sel_s = dst_s;
                    rf_out_en_s  = 1'b1;
                    illegal_s    = !is_defined_op(op_s);
                    state_d      = S_FETCH;
                    case (op_s)
                        OP_ALU: begin
                            alu_opcode_s = fn_s;
                            alu_src1_s   = bus.rf_dst;
                            alu_src2_s   = bus.rf_src;
                            rf_in_s      = bus.alu_dst;
                            rf_in_en_s   = 1'b1;
                        end
                        OP_LD: begin
                            mem_out_en_s   = 1'b1;
                            mem_out_addr_s = bus.rf_src[ADDR_W-1:0];
                            state_d        = S_MEM_WB;
                        end
                        OP_ST: begin
                            mem_in_en_s   = 1'b1;
                            mem_in_addr_s = bus.rf_src[ADDR_W-1:0];
                            mem_in_data_s = bus.rf_dst;
                        end
                        OP_LDI: begin
                            // immediate word sits right after the instruction
                            mem_out_en_s   = 1'b1;
                            mem_out_addr_s = pc_q;
                            pc_d           = pc_inc_s;
                            state_d        = S_MEM_WB;
                        end
                        OP_JMP: begin
                            pc_d = bus.rf_src[ADDR_W-1:0];
                        end
                        OP_HLT: begin
                            state_d = S_HALT;
                        end
                        default: begin
                            // NOP and undefined opcodes: nothing to do
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEM_WB: begin
                    rf_src_sel_s = src_s;
                    rf_dst_sel_s = dst_s;
                    rf_out_en_s  = 1'b1;
                    rf_in_s      = bus.mem_out_data;
                    rf_in_en_s   = 1'b1;
                    state_d      = S_FETCH;
                end
                S_HALT: begin
                    rf_src_sel_s = src_s;
                    rf_dst_sel_s = dst_s;
                    halted_s     = 1'b1;
                    state_d      = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State, pc and ir registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.mem_out_en   = mem_out_en_s;
    assign bus.mem_out_addr = mem_out_addr_s;
    assign bus.mem_in_en    = mem_in_en_s;
    assign bus.mem_in_addr  = mem_in_addr_s;
    assign bus.mem_in_data  = mem_in_data_s;
    assign bus.rf_src_sel   = rf_src_sel_s;
    assign bus.rf_dst_sel   = rf_dst_sel_s;
    assign bus.rf_out_en    = rf_out_en_s;
    assign bus.rf_in_en     = rf_in_en_s;
    assign bus.rf_in        = rf_in_s;
    assign bus.alu_opcode   = alu_opcode_s;
    assign bus.alu_ar_flag  = 1'b0;
    assign bus.alu_src1     = alu_src1_s;
    assign bus.alu_src2     = alu_src2_s;
    assign halted           = halted_s;
    assign illegal          = illegal_s;

endmodule

// File: tb/tb_tiny16_ctrl.sv
// tb_tiny16_ctrl: self-checking bench for tiny16_ctrl.
// The bench owns a memory, a register file and an ALU stub on the slave side
// of the bus, and an instruction-level model of the tiny16 ISA that predicts,
// per instruction, the fetch address, the write events and the latency.
module tb_tiny16_ctrl;
    import tiny16_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tiny16_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    logic halted, illegal;

    tiny16_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .halted  (halted),
        .illegal (illegal)
    );

    // ---------------- environment: memory, register file, ALU ----------------
    logic [15:0] img_mem [256];
    logic [15:0] img_rf  [16];
    logic [15:0] env_mem [256];
    logic [15:0] env_rf  [16];
    logic [15:0] mem_rd_q = 16'h0000;
    logic        load_img = 1'b0;
    logic        alu_force = 1'b0;

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        return (a + b) ^ {12'h000, op};
    endfunction

    assign bus.mem_out_data = mem_rd_q;
    assign bus.rf_src       = env_rf[bus.rf_src_sel];
    assign bus.rf_dst       = env_rf[bus.rf_dst_sel];
    assign bus.alu_dst      = alu_force ? 16'hBEEF : alu_fn(bus.alu_opcode, bus.alu_src1, bus.alu_src2);

    always @(posedge clk) begin
        if (load_img) begin
            env_mem <= img_mem;
            env_rf  <= img_rf;
        end else begin
            if (bus.mem_in_en) env_mem[bus.mem_in_addr] <= bus.mem_in_data;
            if (bus.rf_in_en)  env_rf[bus.rf_dst_sel]   <= bus.rf_in;
        end
        if (bus.mem_out_en) mem_rd_q <= env_mem[bus.mem_out_addr];
    end

    // ---------------- reference model state ----------------
    logic [15:0] m_mem [256];
    logic [15:0] m_rf  [16];
    logic [7:0]  m_pc;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs_vec();
        return {29'h0, bus.mem_out_en, bus.mem_in_en, bus.rf_in_en, bus.rf_out_en, halted, illegal,
                bus.mem_out_addr, bus.mem_in_addr, bus.mem_in_data, bus.rf_src_sel, bus.rf_dst_sel,
                bus.rf_in, bus.alu_opcode, bus.alu_ar_flag, bus.alu_src1, bus.alu_src2};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_from_img();
        for (int i = 0; i < 256; i++) m_mem[i] = img_mem[i];
        for (int i = 0; i < 16; i++)  m_rf[i]  = img_rf[i];
        m_pc = 8'h00;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img_mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++)  img_rf[i]  = 16'h0000;
    endtask

    task automatic rand_img();
        logic [3:0] ops [8];
        ops = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'h2};
        for (int i = 0; i < 256; i++)
            img_mem[i] = {ops[$urandom_range(0, 7)], 12'($urandom)};
        for (int i = 0; i < 16; i++) img_rf[i] = 16'($urandom);
    endtask

    // Hold reset, load the image, check quiet outputs, release; ends at a FETCH sample.
    task automatic do_reset();
        rst      = 1'b1;
        load_img = 1'b1;
        @(posedge clk);
        #1;
        load_img = 1'b0;
        model_from_img();
        step();
        chk("reset_outputs_zero", outs_vec(), 128'h0);
        rst = 1'b0;
        #1;
    endtask

    // Runs one instruction starting at its FETCH sample; checks every cycle
    // against the ISA model and returns at the next FETCH sample.
    task automatic exec_one(output bit hit_halt);
        logic [15:0] instr, wdata_e, mdata_e, a1_e, a2_e, w_data, m_data, a1_o, a2_o;
        logic [3:0]  op, d, s, fn, w_sel, aop_o;
        logic [7:0]  npc, maddr_e, rdaddr_e, m_addr;
        int lat, wcyc_e, w_cyc, n_wr, n_mw, n_ill, ill_cyc, bad_rd, bad_conf, bad_alu;
        bit exp_wr, exp_mw, exp_ill, exp_rd2, is_alu, is_hlt, rd_exp;
        wdata_e = 16'h0; mdata_e = 16'h0; a1_e = 16'h0; a2_e = 16'h0;
        w_data = 16'h0; m_data = 16'h0; a1_o = 16'h0; a2_o = 16'h0;
        w_sel = 4'h0; aop_o = 4'h0; maddr_e = 8'h0; rdaddr_e = 8'h0; m_addr = 8'h0;
        wcyc_e = 0; w_cyc = 0; n_wr = 0; n_mw = 0; n_ill = 0; ill_cyc = 0;
        bad_rd = 0; bad_conf = 0; bad_alu = 0;
        exp_wr = 0; exp_mw = 0; exp_ill = 0; exp_rd2 = 0; is_alu = 0; is_hlt = 0;

        instr = m_mem[m_pc];
        op = instr[15:12]; d = instr[11:8]; s = instr[7:4]; fn = instr[3:0];
        npc = m_pc + 8'd1;
        lat = 3;
        case (op)
            4'h0: ;
            4'h1: begin
                is_alu = 1; a1_e = m_rf[d]; a2_e = m_rf[s];
                wdata_e = alu_force ? 16'hBEEF : alu_fn(fn, a1_e, a2_e);
                exp_wr = 1; wcyc_e = 2;
            end
            4'h3: begin
                exp_rd2 = 1; rdaddr_e = m_rf[s][7:0]; wdata_e = m_mem[rdaddr_e];
                exp_wr = 1; wcyc_e = 3; lat = 4;
            end
            4'h4: begin exp_mw = 1; maddr_e = m_rf[s][7:0]; mdata_e = m_rf[d]; end
            4'h5: begin
                exp_rd2 = 1; rdaddr_e = npc; wdata_e = m_mem[npc]; npc = npc + 8'd1;
                exp_wr = 1; wcyc_e = 3; lat = 4;
            end
            4'h6: npc = m_rf[s][7:0];
            4'hF: is_hlt = 1;
            default: exp_ill = 1;
        endcase

        for (int c = 0; c < lat; c++) begin
            if (c == 0) chk("fetch_addr", {bus.mem_out_en, bus.mem_out_addr}, {1'b1, m_pc});
            rd_exp = (c == 0) || (c == 2 && exp_rd2);
            if (bus.mem_out_en !== rd_exp) bad_rd++;
            if (c == 2 && exp_rd2 && bus.mem_out_addr !== rdaddr_e) bad_rd++;
            if (bus.rf_in_en === 1'b1) begin n_wr++; w_sel = bus.rf_dst_sel; w_data = bus.rf_in; w_cyc = c; end
            if (bus.mem_in_en === 1'b1) begin n_mw++; m_addr = bus.mem_in_addr; m_data = bus.mem_in_data; end
            if (illegal === 1'b1) begin n_ill++; ill_cyc = c; end
            if ((bus.mem_out_en && bus.mem_in_en) || (bus.rf_in_en && bus.mem_out_en) || halted) bad_conf++;
            if (c == 2 && is_alu) begin aop_o = bus.alu_opcode; a1_o = bus.alu_src1; a2_o = bus.alu_src2; end
            else if (bus.alu_opcode != 4'h0 || bus.alu_src1 != 16'h0 || bus.alu_src2 != 16'h0) bad_alu++;
            step();
        end

        chk("read_strobe_pattern", 128'(bad_rd), 128'h0);
        chk("strobe_conflicts", 128'(bad_conf), 128'h0);
        chk("alu_idle_zero", 128'(bad_alu), 128'h0);
        chk("rf_write_count", 128'(n_wr), 128'(exp_wr));
        if (exp_wr) chk("rf_write", {w_sel, w_data, 8'(w_cyc)}, {d, wdata_e, 8'(wcyc_e)});
        chk("mem_write_count", 128'(n_mw), 128'(exp_mw));
        if (exp_mw) chk("mem_write", {m_addr, m_data}, {maddr_e, mdata_e});
        chk("illegal_count", 128'(n_ill), 128'(exp_ill));
        if (exp_ill) chk("illegal_cycle", 128'(ill_cyc), 128'd2);
        if (is_alu) chk("alu_operands", {aop_o, a1_o, a2_o}, {fn, a1_e, a2_e});
        if (is_hlt) chk("halt_entry", {halted, bus.mem_out_en, bus.mem_in_en, bus.rf_in_en, illegal}, 5'b10000);

        if (exp_wr) m_rf[d] = wdata_e;
        if (exp_mw) m_mem[maddr_e] = mdata_e;
        m_pc = npc;
        hit_halt = is_hlt;
    endtask

    initial begin
        bit h;

        // Reset and LDI r2 <- 0x1234; next fetch from 2
        clear_img();
        img_mem[0] = 16'h5200; img_mem[1] = 16'h1234; img_mem[2] = 16'h0000;
        do_reset();
        exec_one(h);
        exec_one(h);
        chk("ldi_next_fetch", {bus.mem_out_en, bus.mem_out_addr}, {1'b1, 8'h03});

        // ALU r1 = r1 op4 r2 with a constant ALU result 0xBEEF
        clear_img();
        img_mem[0] = 16'h1124; img_rf[1] = 16'h1111; img_rf[2] = 16'h2222;
        alu_force = 1'b1;
        do_reset();
        exec_one(h);
        alu_force = 1'b0;

        // ST r1 -> [r2]
        clear_img();
        img_mem[0] = 16'h4120; img_rf[2] = 16'h0010; img_rf[1] = 16'h00AA;
        do_reset();
        exec_one(h);
        exec_one(h);

        // JMP to 0xFF, execute there, pc wraps to 0
        clear_img();
        img_mem[0] = 16'h6030; img_rf[3] = 16'h00FF; img_mem[255] = 16'h0000;
        do_reset();
        exec_one(h);
        exec_one(h);
        exec_one(h);

        // Undefined opcode 0xA, then normal fetch
        clear_img();
        img_mem[0] = 16'hA000;
        do_reset();
        exec_one(h);
        exec_one(h);

        // HLT holds for 20 cycles
        clear_img();
        img_mem[0] = 16'hF000;
        do_reset();
        exec_one(h);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_hold", {halted, bus.mem_out_en, bus.mem_in_en, bus.rf_in_en, bus.rf_out_en, illegal}, 6'b100000);
        end

        // Reset during MEM_WB of LDI r3
        clear_img();
        img_mem[0] = 16'h5300; img_mem[1] = 16'hCAFE; img_rf[3] = 16'h7777;
        do_reset();
        step();
        step();
        step();
        chk("mwb_before_reset", {bus.rf_in_en, bus.rf_dst_sel, bus.rf_in}, {1'b1, 4'h3, 16'hCAFE});
        rst = 1'b1;
        #1;
        chk("mwb_reset_outputs", outs_vec(), 128'h0);
        step();
        rst = 1'b0;
        #1;
        chk("mwb_reg_untouched", env_rf[3], 16'h7777);
        model_from_img();
        exec_one(h);

        // Random programs against the ISA model
        rand_img();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            exec_one(h);
            if (h) begin
                rand_img();
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
